// File: rtl/bist_log_pkg.sv
// Shared types for the SRAM BIST fail logger.
// BIST_LOG_SYNDROME_EN adds the 16-bit read^expected syndrome to each entry.
package bist_log_pkg;

    localparam int LOG_ADDR_W = 18;
    localparam int LOG_DATA_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_CAPTURE = 2'd1;
    localparam state_t S_DRAIN   = 2'd2;
    localparam state_t S_DONE    = 2'd3;

    typedef struct packed {
        logic [LOG_ADDR_W-1:0] address;
`ifdef BIST_LOG_SYNDROME_EN
        logic [LOG_DATA_W-1:0] syndrome;
`endif
    } log_entry_t;

endpackage

// File: rtl/bist_log_fifo.sv
// Small power-of-two FIFO with extra-MSB pointers and a combinational head.
// Entry width follows log_entry_t, so it shrinks without BIST_LOG_SYNDROME_EN.
module bist_log_fifo
    import bist_log_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = log_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Equal low bits: MSB decides whether the ring is full or empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sram_bist_fail_logger.sv
// Logs the first LOG_DEPTH BIST miscompares and drains them afterwards.
// BIST_LOG_SYNDROME_EN stores and presents the per-entry syndrome.
module sram_bist_fail_logger
    import bist_log_pkg::*;
#(
    parameter int LOG_DEPTH   = 8,
    parameter int COUNT_WIDTH = 18
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   BIST_start,
    input  logic                   BIST_finish,
    input  logic                   cmp_valid,
    input  logic [17:0]            cmp_address,
    input  logic [15:0]            cmp_read_data,
    input  logic [15:0]            cmp_expected_data,
    output logic                   log_valid,
    input  logic                   log_ready,
    output logic [17:0]            log_address,
    output logic [15:0]            log_syndrome,
    output logic [COUNT_WIDTH-1:0] log_count,
    output logic                   log_overflow,
    output logic                   log_done
);

    state_t     state;
    logic       start_buf;
    logic       finish_buf;
    logic       start_edge;
    logic       finish_edge;
    logic       mismatch;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    log_entry_t wr_entry;
    log_entry_t head;

    assign start_edge  = BIST_start & ~start_buf;
    assign finish_edge = BIST_finish & ~finish_buf;
    assign mismatch    = cmp_valid && (cmp_read_data != cmp_expected_data);

    // A coincident start edge wins and the mismatch is dropped.
    assign fifo_push = (state == S_CAPTURE) && mismatch && !start_edge;
    assign fifo_pop  = log_valid && log_ready && !start_edge;

    always_comb begin
        wr_entry         = '0;
        wr_entry.address = cmp_address;
`ifdef BIST_LOG_SYNDROME_EN
        wr_entry.syndrome = cmp_read_data ^ cmp_expected_data;
`endif
    end

    bist_log_fifo #(
        .DEPTH   (LOG_DEPTH),
        .entry_t (log_entry_t)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .clear (start_edge),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            start_buf    <= 1'b0;
            finish_buf   <= 1'b0;
            log_count    <= '0;
            log_overflow <= 1'b0;
        end else begin
            start_buf  <= BIST_start;
            finish_buf <= BIST_finish;
            if (start_edge) begin
                state        <= S_CAPTURE;
                log_count    <= '0;
                log_overflow <= 1'b0;
            end else begin
                case (state)
                    S_CAPTURE: begin
                        if (mismatch) begin
                            if (log_count != {COUNT_WIDTH{1'b1}})
                                log_count <= log_count + 1'b1;
                            if (fifo_full) log_overflow <= 1'b1;
                        end
                        if (finish_edge) state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (fifo_empty) state <= S_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign log_valid   = (state == S_DRAIN) && !fifo_empty;
    assign log_done    = (state == S_DONE);
    assign log_address = head.address;
`ifdef BIST_LOG_SYNDROME_EN
    assign log_syndrome = head.syndrome;
`else
    assign log_syndrome = 16'd0;
`endif

endmodule

// File: tb/tb_sram_bist_fail_logger.sv
// Directed bench for sram_bist_fail_logger, plus a 4-bit counter instance
// sharing the same stimulus to exercise saturation.
module tb_sram_bist_fail_logger;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        BIST_start;
    logic        BIST_finish;
    logic        cmp_valid;
    logic [17:0] cmp_address;
    logic [15:0] cmp_read_data;
    logic [15:0] cmp_expected_data;
    logic        log_ready;

    logic        log_valid;
    logic [17:0] log_address;
    logic [15:0] log_syndrome;
    logic [17:0] log_count;
    logic        log_overflow;
    logic        log_done;

    logic        s_valid;
    logic [17:0] s_address;
    logic [15:0] s_syndrome;
    logic [3:0]  s_count;
    logic        s_overflow;
    logic        s_done;

    int checks = 0;
    int errors = 0;

`ifdef BIST_LOG_SYNDROME_EN
    localparam logic SYN_ON = 1'b1;
`else
    localparam logic SYN_ON = 1'b0;
`endif

    always #5 Clock = ~Clock;

    sram_bist_fail_logger #(.LOG_DEPTH(8), .COUNT_WIDTH(18)) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .BIST_start        (BIST_start),
        .BIST_finish       (BIST_finish),
        .cmp_valid         (cmp_valid),
        .cmp_address       (cmp_address),
        .cmp_read_data     (cmp_read_data),
        .cmp_expected_data (cmp_expected_data),
        .log_valid         (log_valid),
        .log_ready         (log_ready),
        .log_address       (log_address),
        .log_syndrome      (log_syndrome),
        .log_count         (log_count),
        .log_overflow      (log_overflow),
        .log_done          (log_done)
    );

    sram_bist_fail_logger #(.LOG_DEPTH(8), .COUNT_WIDTH(4)) u_sat (
        .Clock             (Clock),
        .Reset             (Reset),
        .BIST_start        (BIST_start),
        .BIST_finish       (BIST_finish),
        .cmp_valid         (cmp_valid),
        .cmp_address       (cmp_address),
        .cmp_read_data     (cmp_read_data),
        .cmp_expected_data (cmp_expected_data),
        .log_valid         (s_valid),
        .log_ready         (log_ready),
        .log_address       (s_address),
        .log_syndrome      (s_syndrome),
        .log_count         (s_count),
        .log_overflow      (s_overflow),
        .log_done          (s_done)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [17:0] a, input logic [15:0] rd,
                          input logic [15:0] ex);
        cmp_valid         = 1'b1;
        cmp_address       = a;
        cmp_read_data     = rd;
        cmp_expected_data = ex;
        tick();
        cmp_valid = 1'b0;
    endtask

    task automatic end_run();
        BIST_start  = 1'b0;
        BIST_finish = 1'b0;
        log_ready   = 1'b0;
        tick();
    endtask

    initial begin
        Reset             = 1'b1;
        BIST_start        = 1'b0;
        BIST_finish       = 1'b0;
        cmp_valid         = 1'b0;
        cmp_address       = '0;
        cmp_read_data     = '0;
        cmp_expected_data = '0;
        log_ready         = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(log_valid), 32'd0);
        chk("rst_count", 32'(log_count), 32'd0);
        chk("rst_ovf", 32'(log_overflow), 32'd0);
        chk("rst_done", 32'(log_done), 32'd0);
        Reset = 1'b0;
        tick();

        // No failures
        BIST_start = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            strobe(18'(i), 16'hA5A5, 16'hA5A5);
            chk("nofail_valid", 32'(log_valid), 32'd0);
        end
        BIST_finish = 1'b1;
        tick();
        chk("nofail_drain_valid", 32'(log_valid), 32'd0);
        chk("nofail_done_early", 32'(log_done), 32'd0);
        tick();
        chk("nofail_done", 32'(log_done), 32'd1);
        chk("nofail_count", 32'(log_count), 32'd0);
        end_run();

        // Three failures, drain order and syndrome
        BIST_start = 1'b1;
        tick();
        chk("three_done_clr", 32'(log_done), 32'd0);
        strobe(18'h00010, 16'h0014, 16'h0015);
        strobe(18'h00011, 16'h0014, 16'h0015);
        strobe(18'h3FFFE, 16'h0014, 16'h0015);
        chk("three_count", 32'(log_count), 32'd3);
        BIST_finish = 1'b1;
        tick();
        log_ready = 1'b1;
        chk("three_v0", 32'(log_valid), 32'd1);
        chk("three_a0", 32'(log_address), 32'h00010);
        chk("three_s0", 32'(log_syndrome), SYN_ON ? 32'h1 : 32'h0);
        tick();
        chk("three_a1", 32'(log_address), 32'h00011);
        tick();
        chk("three_a2", 32'(log_address), 32'h3FFFE);
        chk("three_v2", 32'(log_valid), 32'd1);
        tick();
        chk("three_empty", 32'(log_valid), 32'd0);
        tick();
        chk("three_done", 32'(log_done), 32'd1);
        end_run();

        // Overflow
        BIST_start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            strobe(18'h100 + 18'(i), 16'h0000, 16'hFFFF);
            if (i == 7) chk("ovf_not_yet", 32'(log_overflow), 32'd0);
        end
        chk("ovf_count", 32'(log_count), 32'd10);
        chk("ovf_flag", 32'(log_overflow), 32'd1);
        BIST_finish = 1'b1;
        tick();
        log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_dv", 32'(log_valid), 32'd1);
            chk("ovf_da", 32'(log_address), 32'h100 + 32'(i));
            tick();
        end
        chk("ovf_empty", 32'(log_valid), 32'd0);
        tick();
        chk("ovf_done", 32'(log_done), 32'd1);
        chk("ovf_sticky", 32'(log_overflow), 32'd1);
        end_run();

        // Backpressure 1,0,0,1
        BIST_start = 1'b1;
        tick();
        strobe(18'h20, 16'h1234, 16'h1230);
        strobe(18'h21, 16'h1234, 16'h1230);
        strobe(18'h22, 16'h1234, 16'h1230);
        chk("bp_ovf_clr", 32'(log_overflow), 32'd0);
        BIST_finish = 1'b1;
        tick();
        log_ready = 1'b1;
        chk("bp_a0", 32'(log_address), 32'h20);
        chk("bp_s0", 32'(log_syndrome), SYN_ON ? 32'h4 : 32'h0);
        tick();
        log_ready = 1'b0;
        chk("bp_a1_r0", 32'(log_address), 32'h21);
        tick();
        chk("bp_a1_hold", 32'(log_address), 32'h21);
        chk("bp_v_hold", 32'(log_valid), 32'd1);
        tick();
        log_ready = 1'b1;
        chk("bp_a1_r1", 32'(log_address), 32'h21);
        tick();
        chk("bp_a2", 32'(log_address), 32'h22);
        tick();
        chk("bp_empty", 32'(log_valid), 32'd0);
        tick();
        chk("bp_done", 32'(log_done), 32'd1);
        end_run();

        // Restart mid-drain with coincident mismatch
        BIST_start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++)
            strobe(18'h40 + 18'(i), 16'h0F0F, 16'h0F0E);
        BIST_finish = 1'b1;
        tick();
        log_ready = 1'b1;
        chk("rs_a0", 32'(log_address), 32'h40);
        tick();
        chk("rs_a1", 32'(log_address), 32'h41);
        tick();
        log_ready   = 1'b0;
        BIST_start  = 1'b0;
        BIST_finish = 1'b0;
        tick();
        chk("rs_still_drain", 32'(log_address), 32'h42);
        BIST_start = 1'b1;
        strobe(18'h55, 16'h0001, 16'h0002);
        chk("rs_state", 32'(dut.state), 32'd1);
        chk("rs_count", 32'(log_count), 32'd0);
        chk("rs_ovf", 32'(log_overflow), 32'd0);
        chk("rs_valid", 32'(log_valid), 32'd0);
        BIST_finish = 1'b1;
        tick();
        chk("rs_fifo_empty", 32'(log_valid), 32'd0);
        tick();
        chk("rs_done", 32'(log_done), 32'd1);
        chk("rs_count2", 32'(log_count), 32'd0);
        end_run();

        // Saturation and asynchronous reset
        BIST_start = 1'b1;
        tick();
        for (int i = 0; i < 20; i++)
            strobe(18'h200 + 18'(i), 16'h8000, 16'h0000);
        chk("sat_wide", 32'(log_count), 32'd20);
        chk("sat_narrow", 32'(s_count), 32'hF);
        chk("sat_ovf", 32'(s_overflow), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_count", 32'(log_count), 32'd0);
        chk("arst_ovf", 32'(log_overflow), 32'd0);
        chk("arst_scount", 32'(s_count), 32'd0);
        chk("arst_sovf", 32'(s_overflow), 32'd0);
        chk("arst_valid", 32'(log_valid), 32'd0);
        chk("arst_done", 32'(log_done), 32'd0);
        chk("arst_state", 32'(dut.state), 32'd0);
        tick();
        Reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bist_fail_logger.md
Name: sram_bist_fail_logger

Overview:
- Sits directly downstream of the SRAM BIST engine.
- Consumes the per-read compare stream: address, read data and expected data qualified by a valid strobe.
- Records the first LOG_DEPTH failing addresses in a small FIFO and keeps a saturating total mismatch count.
- After BIST finishes, drains the logged failures through a valid/ready port to the board-level reporter (UART/7-seg).

Parameters:
- LOG_DEPTH, 8, number of failure entries stored; power of two, 2..32.
- COUNT_WIDTH, 18, width of the saturating total-mismatch counter.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- BIST_start  input  1  same start level driven to the BIST engine; the rising edge arms the logger.
- BIST_finish  input  1  BIST engine finish flag; the rising edge ends capture.
- cmp_valid  input  1  compare strobe; cmp_* fields are valid this cycle.
- cmp_address  input  18  SRAM address of the compared word.
- cmp_read_data  input  16  data returned by SRAM.
- cmp_expected_data  input  16  expected background value.
- log_valid  output  1  head entry available.
- log_ready  input  1  consumer accepts head entry.
- log_address  output  18  failing address at FIFO head.
- log_syndrome  output  16  read XOR expected at FIFO head (see Optional Feature).
- log_count  output  COUNT_WIDTH  total mismatches this run, saturating.
- log_overflow  output  1  more mismatches occurred than LOG_DEPTH.
- log_done  output  1  capture finished and FIFO fully drained.

Behaviour:
- Reset (async, Reset=1): state S_IDLE; FIFO empty with pointers 0; log_count=0; log_overflow=0; log_done=0; log_valid=0. Start/finish edge buffers are cleared to 0.
- Edge detect: start_buf and finish_buf are registered copies of the inputs. A start edge is BIST_start & ~start_buf; a finish edge is defined the same way.
- S_IDLE: on a start edge, clear the FIFO, log_count, log_overflow and log_done, then go to S_CAPTURE.
- S_CAPTURE, each cycle with cmp_valid=1 and cmp_read_data != cmp_expected_data:
  - log_count increments by 1, saturating at all-ones.
  - If the FIFO is not full, push {cmp_address, syndrome}; otherwise set log_overflow=1 (sticky until the next start edge).
  - The count and FIFO update become visible one cycle after the strobe.
- S_CAPTURE on a finish edge: go to S_DRAIN. A mismatch in the same cycle as the finish edge is still logged.
- S_DRAIN:
  - log_valid = FIFO not empty.
  - log_address and log_syndrome come combinationally from the head entry.
  - Pop when log_valid & log_ready.
  - When the FIFO is empty (including on entry with zero failures), go to S_DONE the next cycle.
- S_DONE: log_done=1, held. A start edge clears everything and goes to S_CAPTURE.
- log_valid is forced 0 outside S_DRAIN; pushes and pops never occur in the same state.
- A start edge in any state (including mid-capture or mid-drain) aborts and re-arms. Clear takes priority over a coincident mismatch, and that mismatch is dropped.
- cmp_valid is ignored outside S_CAPTURE.
- FIFO pointers are log2(LOG_DEPTH)+1 bits wide, wrap naturally, and full/empty is decided by the MSB compare.
- Reset mid-operation returns to the reset values immediately; no partial results are retained.

Optional Feature:
- Macro BIST_LOG_SYNDROME_EN.
- Defined: each entry stores the 16-bit syndrome cmp_read_data ^ cmp_expected_data, and log_syndrome presents it at the head.
- Undefined: entries store only the 18-bit address, and log_syndrome is tied to 16'd0. The FIFO storage shrinks accordingly.

Decomposition:
- Package bist_log_pkg holds:
  - the state enum {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE};
  - the entry struct (address and, conditionally, syndrome);
  - constants LOG_ADDR_W=18, LOG_DATA_W=16.
- One sub-module, bist_log_fifo:
  - parameterised by depth and entry type;
  - push/pop/full/empty;
  - combinational head read.

Test Plan:
- No failures: start edge, 16 strobes with read==expected, finish edge → log_count=0, log_valid never 1, log_done=1 two cycles after the finish edge.
- Three failures at addresses 18'h00010, 18'h00011, 18'h3FFFE, with read 16'h0014 vs expected 16'h0015 → log_count=3 and drain order matches. With the macro, the syndrome for the first entry is 16'h0001; without it, the syndrome is 0.
- Overflow: 10 failures with LOG_DEPTH=8 → log_count=10, log_overflow=1, only the first 8 addresses are drained.
- Backpressure: during drain, log_ready toggles 1,0,0,1 → each entry is held stable while ready=0; no loss or duplication.
- Restart mid-drain: start edge after 2 of 5 entries are popped → FIFO empty, count=0, overflow=0, state S_CAPTURE. A mismatch coincident with the start edge is not counted.
- Saturation: COUNT_WIDTH=4 with 20 failures → log_count holds at 4'hF; async Reset pulse → all outputs return to 0 without waiting for a clock edge.
